uart_rx_autobaud: RTL
=====================

# uart_rx_autobaud

Byte receiver that sits directly downstream of the auto-baud measurement circuit (ABRCKT). It takes the measured bit period (`baud_div`) and the serial line `UxRX`, detects start bits, and samples 8 data bits LSB-first at mid-bit, followed by one stop bit. It presents each received byte with a sticky `UxRXIF` flag plus framing and overrun status. While `ABAUD` is high, ABRCKT owns the line and the receiver is held idle.

## Interface
- `DIV_MIN`, default 4 — smallest usable bit period in clk cycles; smaller `baud_div` values are clamped up to it.
- `clk` input 1 — single clock; all logic is rising-edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `UxRX` input 1 — asynchronous serial line; idles high.
- `ABAUD` input 1 — auto-baud in progress; forces IDLE and suppresses reception.
- `baud_div` input 8 — bit period in clk cycles (ABRCKT `out`); sampled at start-bit detection.
- `rx_ack` input 1 — consumer read strobe; clears `UxRXIF`.
- `err_clr` input 1 — clears `ferr` and `oerr`.
- `rx_data` output 8 — last accepted byte.
- `UxRXIF` output 1 — byte available (sticky).
- `rx_valid` output 1 — one-cycle pulse per accepted byte.
- `ferr` output 1 — sticky framing error.
- `oerr` output 1 — sticky overrun error.
- `busy` output 1 — high in every state except IDLE.

## Operation
- `UxRX` passes through a fixed 2-flop synchroniser, giving `rx_s`; `rx_q` is `rx_s` delayed one cycle.
- Effective divisor D is `max(baud_div, DIV_MIN)`. It is latched on start detection and held for the whole frame.
- States: IDLE, START, DATA, PARITY (only if the macro is defined), STOP.
- IDLE → START when `rx_q`=1 and `rx_s`=0 and `ABAUD`=0. The bit timer is loaded with floor(D/2)−1.
- START, on timer expiry:
  - `rx_s`=1 is a false start → IDLE, with no flags changed.
  - `rx_s`=0 → DATA, timer loaded with D−1, bit index 0.
- DATA: on each expiry, `rx_s` shifts into bit[index], LSB first. After index 7 → PARITY or STOP, timer D−1.
- STOP, on expiry:
  - `rx_s`=1 accepts the byte.
  - `rx_s`=0: `ferr` is set, the byte is discarded, `UxRXIF` is untouched.
  - Either way → IDLE.
- A new start is only recognised after `rx_s` is seen high (edge detect), so a held-low line does not retrigger.
- Accept rules:
  - If `UxRXIF`=0, or `rx_ack`=1 in the same cycle: `rx_data` is updated, `UxRXIF` set, `rx_valid` pulsed.
  - Otherwise `oerr` is set, `rx_data` is kept and no pulse is issued.
- `rx_ack` with no simultaneous accept clears `UxRXIF`.
- Same-cycle accept and `rx_ack`: `UxRXIF` stays 1 with the new data.
- `err_clr` clears both `ferr` and `oerr`. A same-cycle set wins over the clear.
- `ABAUD`=1 in any state → IDLE next cycle. The partial byte is dropped and no flags change.
- Reset values:
  - `rx_data`=0x00.
  - `UxRXIF`, `rx_valid`, `ferr`, `oerr`, `busy` all 0.
  - State IDLE.
  - Synchroniser flops = 1.
- Reset mid-frame abandons the frame.

## Timing
- t0 is the first cycle with `rx_s`=0. The line-to-`rx_s` delay is 2 cycles.
- Start sample at t0+floor(D/2).
- Data bit i sampled at t0+floor(D/2)+(i+1)·D.
- Stop sampled at t0+floor(D/2)+9·D, or +10·D with parity.
- `rx_data`, `UxRXIF` and `rx_valid` are visible the cycle after the stop sample. `rx_valid` is exactly 1 cycle wide.
- The same timing applies to `ferr` on a bad stop bit.
- `busy` rises the cycle after t0 and falls with the return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and a `perr` output (sticky, reset 0, cleared by `err_clr`).
  - Even parity over the 8 data bits is checked at mid-bit.
  - A mismatch sets `perr`; the byte is still accepted if the stop bit is good.
- Undefined: no PARITY state, no `perr` port, frame is 10 bits.

## Structure
- Package `uart_pkg` holds:
  - the state enum;
  - `DATA_BITS`=8;
  - the `DIV_MIN` default;
  - the width of the divisor, 8.
- Sub-module `uart_bit_timer`: an 8-bit down-counter with load value and `expire` pulse, reused by the transmitter.

## Test plan
- D=16, frame 0xA5 (8N1):
  - `rx_data`=0xA5 and a single `rx_valid` pulse the cycle after the stop sample.
  - `UxRXIF`=1 until `rx_ack`.
- D=16, 1-cycle glitch low on `UxRX` → start sample reads 1; back to IDLE, no flags.
- D=16, 0x3C with stop bit 0 → `ferr`=1, `rx_data` unchanged, `UxRXIF`=0.
- D=16, 0x11 then 0x22 with no `rx_ack` → `oerr`=1 and `rx_data`=0x11. Repeating the test with `rx_ack` coincident with the second accept → `rx_data`=0x22, `oerr`=0.
- `baud_div`=2, 0x5A sent at 4-cycle bits → received 0x5A (clamp). Separately, `ABAUD` asserted mid-byte → IDLE next cycle, no flag change.
- With `UART_RX_PARITY_EN`, D=8, 0x07 with parity bit 0 → `perr`=1, `rx_data`=0x07, `UxRXIF`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit blocks.
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int DIV_W       = 8;
    localparam int DIV_MIN_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } rx_state_e;

    // Bit period actually used by the receiver: the measured value, floored at dmin.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div,
                                                 input logic [DIV_W-1:0] dmin);
        return (div < dmin) ? dmin : div;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; expire is high while enabled and the count sits at zero.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expire
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_rx_autobaud.sv
// 8N1 byte receiver driven by the auto-baud bit period; ABAUD holds it idle.
// Optional even-parity bit and perr output when UART_RX_PARITY_EN is defined.
module uart_rx_autobaud
    import uart_pkg::*;
#(
    parameter int DIV_MIN = DIV_MIN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 UxRX,
    input  logic                 ABAUD,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rx_ack,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 UxRXIF,
    output logic                 rx_valid,
    output logic                 ferr,
    output logic                 oerr,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 perr
`endif
);

    localparam logic [DIV_W-1:0] DMIN = DIV_W'(DIV_MIN);

    rx_state_e              state_q, state_d;
    logic                   rx_m, rx_s, rx_q;
    logic [DIV_W-1:0]       div_eff, d_q, tmr_val;
    logic                   tmr_load, expire;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   shift_en, idx_clr, acc_stb, fe_stb, par_bad;
    logic                   take, ovr;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= UxRX;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    assign div_eff = eff_div(baud_div, DMIN);
    assign busy    = (state_q != S_IDLE);

    uart_bit_timer u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = d_q - 1'b1;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        acc_stb  = 1'b0;
        fe_stb   = 1'b0;
        par_bad  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_q && !rx_s) begin
                    state_d  = S_START;
                    tmr_load = 1'b1;
                    tmr_val  = (div_eff >> 1) - 1'b1;
                end
            end
            S_START: begin
                if (expire) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        tmr_load = 1'b1;
                        idx_clr  = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_en = 1'b1;
                    tmr_load = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire) begin
                    par_bad  = (rx_s != ^shreg);
                    state_d  = S_STOP;
                    tmr_load = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (expire) begin
                    acc_stb = rx_s;
                    fe_stb  = !rx_s;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Auto-baud owns the line: drop everything, touch no flags.
        if (ABAUD) begin
            state_d  = S_IDLE;
            tmr_load = 1'b0;
            shift_en = 1'b0;
            idx_clr  = 1'b0;
            acc_stb  = 1'b0;
            fe_stb   = 1'b0;
            par_bad  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q     <= DMIN;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_q == S_IDLE && tmr_load)
                d_q <= div_eff;
            if (idx_clr)
                bit_idx <= '0;
            else if (shift_en) begin
                shreg[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    assign take = acc_stb && (!UxRXIF || rx_ack);
    assign ovr  = acc_stb && UxRXIF && !rx_ack;

    // Error flags: a same-cycle set beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data  <= '0;
            UxRXIF   <= 1'b0;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            oerr     <= 1'b0;
        end else begin
            rx_valid <= take;
            if (take) begin
                rx_data <= shreg;
                UxRXIF  <= 1'b1;
            end else if (rx_ack) begin
                UxRXIF  <= 1'b0;
            end
            ferr <= fe_stb | (ferr & ~err_clr);
            oerr <= ovr    | (oerr & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            perr <= 1'b0;
        else
            perr <= par_bad | (perr & ~err_clr);
    end
`endif

endmodule
